// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch front end: queue entry layout and B-opcode helpers.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fetch_pkg;

    localparam int FQ_DEPTH   = 4;
    localparam int FQ_ADDR_W  = 64;
    localparam int FQ_INSTR_W = 32;

    localparam logic [5:0] OPC_B = 6'b000101;

    typedef struct packed {
        logic [FQ_ADDR_W-1:0]  pc;
        logic [FQ_INSTR_W-1:0] instr;
    } fq_entry_t;

    function automatic logic isBranch(input logic [FQ_INSTR_W-1:0] instr);
        return instr[31:26] == OPC_B;
    endfunction

    // Word offset in bits[25:0], sign-extended and scaled to bytes.
    function automatic logic [FQ_ADDR_W-1:0] branchTarget(input logic [FQ_ADDR_W-1:0]  pc,
                                                          input logic [FQ_INSTR_W-1:0] instr);
        return pc + {{(FQ_ADDR_W-28){instr[25]}}, instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory request/response, redirect and decode-side head.
// Latency: none (wires only).
// Backpressure: decode holds entries by keeping deq_ready low.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = FQ_ADDR_W,
    parameter int INSTR_W = FQ_INSTR_W
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               deq_ready;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_instr, redirect_valid, redirect_pc, deq_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_instr, redirect_valid, redirect_pc, deq_ready
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// Circular buffer of fetched {pc, instr} entries with push, pop, flush and occupancy count.
// Latency: a pushed entry is at the head the cycle after the push (no bypass).
// Backpressure: caller must not push while full; pop while empty is ignored.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fq_entry_t              pushDat,
    input  logic                   pop,
    output fq_entry_t              headDat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             pushOk;
    logic             popOk;

    assign pushOk  = push && !flush;
    assign popOk   = pop && !flush && (count != '0);
    assign headDat = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr] <= pushDat;
        end
    end

    // Power-of-two depth: pointer wrap is plain overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
            if (popOk)  rdPtr <= rdPtr + PTR_W'(1);
            count <= count + CNT_W'(pushOk) - CNT_W'(popOk);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns fetch PC, issues sequential imem requests, queues returns for decode.
// Latency: request to out_valid is 2 cycles; redirect target visible at R+3. Optional FETCH_PREDECODE_EN.
// Backpressure: issue stalls while queued + in-flight entries reach DEPTH; decode pops via deq_ready.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH   = FQ_DEPTH,
    parameter int ADDR_W  = FQ_ADDR_W,
    parameter int INSTR_W = FQ_INSTR_W
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.master fq
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetchPc;
    logic [ADDR_W-1:0] inflightPc;
    logic              inflight;
    logic              inflightEpoch;
    logic              epoch;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic              respVld;
    logic              issue;
    logic              pop;
    logic              pdHit;
    fq_entry_t         pushDat;
    fq_entry_t         headDat;

    // A response from before the latest redirect carries a stale epoch and is dropped.
    assign respVld   = inflight && (inflightEpoch == epoch) && !fq.redirect_valid;
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign pop       = fq.deq_ready && fq.out_valid && !fq.redirect_valid;
    assign pushDat   = '{pc: inflightPc, instr: fq.imem_instr};

`ifdef FETCH_PREDECODE_EN
    logic [ADDR_W-1:0] pdTarget;
    assign pdHit    = respVld && isBranch(fq.imem_instr);
    assign pdTarget = branchTarget(inflightPc, fq.imem_instr);
`else
    assign pdHit = 1'b0;
`endif

    // Occupancy uses pre-dequeue count so deq_ready never reaches imem_req combinationally.
    assign issue = !rst && !fq.redirect_valid && !pdHit && (occupancy < (CNT_W+1)'(DEPTH));

    assign fq.imem_req  = issue;
    assign fq.imem_addr = fetchPc;
    assign fq.out_valid = (count != '0);
    assign fq.out_instr = fq.out_valid ? headDat.instr : '0;
    assign fq.out_pc    = fq.out_valid ? headDat.pc    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc       <= '0;
            inflight      <= 1'b0;
            inflightPc    <= '0;
            inflightEpoch <= 1'b0;
            epoch         <= 1'b0;
        end else if (fq.redirect_valid) begin
            fetchPc  <= fq.redirect_pc;
            epoch    <= ~epoch;
            inflight <= 1'b0;
`ifdef FETCH_PREDECODE_EN
        end else if (pdHit) begin
            fetchPc  <= pdTarget;
            epoch    <= ~epoch;
            inflight <= 1'b0;
`endif
        end else begin
            inflight <= issue;
            if (issue) begin
                fetchPc       <= fetchPc + ADDR_W'(4);
                inflightPc    <= fetchPc;
                inflightEpoch <= epoch;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (fq.redirect_valid),
        .push    (respVld),
        .pushDat (pushDat),
        .pop     (pop),
        .headDat (headDat),
        .count   (count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a stream-level reference model.
module tb_fetch_queue;
    import fetch_pkg::*;

`ifdef FETCH_PREDECODE_EN
    localparam bit PD = 1'b1;
`else
    localparam bit PD = 1'b0;
`endif
    localparam int          DEPTH  = FQ_DEPTH;
    localparam logic [63:0] B_ADDR = 64'h20;
    localparam logic [31:0] B_WORD = {6'b000101, 26'd8};

    logic clk = 1'b0;
    logic rst;

    fetch_queue_if fq();

    fetch_queue dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Memory image: PC-tagged words, with one B (+8 words) planted at 0x20.
    function automatic logic [31:0] memWord(input logic [63:0] pc);
        if (pc == B_ADDR) return B_WORD;
        return {6'h3f, pc[27:2]};
    endfunction

    function automatic logic [63:0] nextPc(input logic [63:0] pc);
        if (PD && pc == B_ADDR) return pc + 64'd32;
        return pc + 64'd4;
    endfunction

    // Reference state: outstanding = issued-not-dequeued since last flush,
    // visible = entries decode can see, reqPc/expPc = next address requested / dequeued.
    int          outstanding;
    int          visible;
    logic [63:0] reqPc;
    logic [63:0] expPc;
    logic [63:0] respPc;
    bit          respPending;

    task automatic step(input bit r, input bit redir, input logic [63:0] rpc, input bit deq);
        bit          expReq;
        bit          pdHit;
        bit          deqNow;
        logic        smpReq;
        logic [63:0] smpAddr;

        rst               = r;
        fq.redirect_valid = redir;
        fq.redirect_pc    = rpc;
        fq.deq_ready      = deq;
        #1;
        pdHit  = PD && respPending && (respPc == B_ADDR) && !redir && !r;
        expReq = !r && !redir && (outstanding < DEPTH) && !pdHit;
        if (r) begin
            checkEq("req_in_rst", 64'(fq.imem_req), 64'd0);
        end else begin
            checkEq("imem_req",  64'(fq.imem_req),  64'(expReq));
            checkEq("imem_addr", fq.imem_addr,      reqPc);
            checkEq("out_valid", 64'(fq.out_valid), 64'(visible > 0));
            checkEq("out_pc",    fq.out_pc,         (visible > 0) ? expPc : 64'd0);
            checkEq("out_instr", 64'(fq.out_instr), (visible > 0) ? 64'(memWord(expPc)) : 64'd0);
        end
        smpReq  = fq.imem_req;
        smpAddr = fq.imem_addr;

        @(posedge clk);
        if (r) begin
            outstanding = 0; visible = 0; reqPc = '0; expPc = '0; respPending = 0;
        end else if (redir) begin
            outstanding = 0; visible = 0; reqPc = rpc; expPc = rpc; respPending = 0;
        end else begin
            deqNow = deq && (visible > 0);
            if (respPending) visible++;
            if (deqNow) begin
                visible--;
                outstanding--;
                expPc = nextPc(expPc);
            end
            if (pdHit) begin
                reqPc       = respPc + 64'd32;
                respPending = 0;
            end else if (expReq) begin
                respPc      = reqPc;
                reqPc       = reqPc + 64'd4;
                outstanding++;
                respPending = 1;
            end else begin
                respPending = 0;
            end
        end
        #1;
        fq.imem_instr = smpReq ? memWord(smpAddr) : 32'($urandom());
        @(negedge clk);
    endtask

    function automatic logic [63:0] randTarget();
        case ($urandom_range(0, 4))
            0:       return 64'h0;
            1:       return 64'h100;
            2:       return 64'h18;
            3:       return 64'hFFFF_FFFF_FFFF_FFF8;
            default: return 64'($urandom_range(0, 255)) << 2;
        endcase
    endfunction

    initial begin
        int bias;
        rst               = 1'b1;
        fq.redirect_valid = 1'b0;
        fq.redirect_pc    = '0;
        fq.deq_ready      = 1'b0;
        fq.imem_instr     = '0;
        outstanding = 0; visible = 0; reqPc = '0; expPc = '0; respPc = '0; respPending = 0;
        @(negedge clk);

        repeat (2) step(1, 0, '0, 1);
        // Streaming with decode always ready, through the planted B.
        repeat (20) step(0, 0, '0, 1);
        // Decode stall: queue fills to DEPTH, then fetch stops.
        repeat (12) step(0, 0, '0, 0);
        repeat (12) step(0, 0, '0, 1);
        // Build 3 queued + 1 in flight, then redirect to 0x100.
        step(0, 1, 64'h0, 0);
        repeat (4) step(0, 0, '0, 0);
        step(0, 1, 64'h100, 0);
        repeat (8) step(0, 0, '0, 1);
        // Back-to-back redirects: only the 0x300 stream survives.
        step(0, 1, 64'h200, 1);
        step(0, 1, 64'h300, 1);
        repeat (10) step(0, 0, '0, 1);
        // Full queue with simultaneous pop and incoming response.
        repeat (6) step(0, 0, '0, 0);
        repeat (20) step(0, 0, '0, 1);
        // Wrap of PC at 2^64.
        step(0, 1, 64'hFFFF_FFFF_FFFF_FFF0, 1);
        repeat (12) step(0, 0, '0, 1);

        for (int blk = 0; blk < 15; blk++) begin
            bias = $urandom_range(1, 9);
            for (int c = 0; c < 200; c++) begin
                step(0, $urandom_range(0, 19) == 0, randTarget(), $urandom_range(0, 9) < bias);
            end
        end

        // Reset mid-stream overrides a concurrent redirect and dequeue.
        step(1, 1, 64'h400, 1);
        repeat (12) step(0, 0, '0, 1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
